// File: rtl/voice_mixer.sv
// Voice mixer: sweeps the time-multiplexed oscillator once per frame, sums the voices,
// applies master volume with saturation and hands one sample per frame over valid/ready.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif

module voice_mixer #(
  parameter int WIDTH      = 24,
  parameter int FRAC       = `FIXED_POINT,
  parameter int N_WAVEGENS = `N_OSCILLATORS,
  parameter int OUT_WIDTH  = 24
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [7:0]                           master_volume,
  input  logic signed [WIDTH+FRAC-1:0]         osc_out,
  input  logic                                 osc_enabled,
  output logic [$clog2(N_WAVEGENS+1)-1:0]      index,
  output logic signed [OUT_WIDTH-1:0]          out,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(N_WAVEGENS+1)-1:0]      active_voices,
  output logic                                 clip,
  output logic [1:0]                           status
);

  localparam int IW = $clog2(N_WAVEGENS + 1);
  localparam int AW = WIDTH + FRAC + $clog2(N_WAVEGENS) + 1;
  localparam int PW = AW + 9;
  localparam logic signed [PW-1:0] MAXV = {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SWEEP, MUL, SAT} state_t;

  state_t                 state, state_d;
  logic signed [AW-1:0]   acc;
  logic [IW-1:0]          cnt;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   shifted;
  logic signed [OUT_WIDTH-1:0] sat_val;
  logic                   clamped;
  logic                   armed;
  logic                   go;
  logic                   last;

  // armed blocks a start sampled on the very edge that releases reset
  assign go   = start && armed;
  assign last = (index == IW'(N_WAVEGENS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (go) state_d = SWEEP;
      SWEEP:   if (last) state_d = MUL;
      MUL:     state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shifted = prod >>> (8 + FRAC);
    clamped = 1'b0;
    sat_val = shifted[OUT_WIDTH-1:0];
    if (shifted > MAXV) begin
      sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      clamped = 1'b1;
    end else if (shifted < MINV) begin
      sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      clamped = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      index         <= IW'(N_WAVEGENS);
      acc           <= '0;
      cnt           <= '0;
      prod          <= '0;
      out           <= '0;
      out_valid     <= 1'b0;
      clip          <= 1'b0;
      active_voices <= '0;
      status        <= '0;
      armed         <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (start && state != IDLE) status[0] <= 1'b1;
      case (state)
        IDLE: if (go) begin
          acc   <= '0;
          cnt   <= '0;
          index <= '0;
        end
        SWEEP: begin
          acc   <= acc + AW'(osc_out);
          cnt   <= cnt + IW'(osc_enabled);
          index <= last ? IW'(N_WAVEGENS) : index + IW'(1);
        end
        MUL: prod <= PW'(acc) * PW'($signed({1'b0, master_volume}));
        default: ;
      endcase
      // a new sample always wins over a same-edge transfer; an untaken one is overwritten
      if (state == SAT) begin
        out           <= sat_val;
        clip          <= clamped;
        active_voices <= cnt;
        out_valid     <= 1'b1;
        if (out_valid && !out_ready) status[1] <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Downstream companion to the time-multiplexed `oscillator`: drives its `index` sweep once per output sample, sums the `N_WAVEGENS` per-voice outputs, applies a master volume with saturation, and presents one mixed sample per frame to the audio output stage over a valid/ready handshake. It also reports per-frame active-voice count and sticky timing-fault flags.

## Interface

- `WIDTH`, 24, oscillator sample integer width; matches `oscillator.WIDTH`.
- `FRAC`, `` `FIXED_POINT ``, fractional bits on oscillator `out`.
- `N_WAVEGENS`, `` `N_OSCILLATORS ``, voices per frame; must be ≥ 2.
- `OUT_WIDTH`, 24, signed width of mixed output.

- `clk`  in  1  system clock, shared with `oscillator`.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle frame strobe at sample rate.
- `master_volume`  in  8  unsigned gain; gain = value/256.
- `osc_out`  in  WIDTH+FRAC  signed, oscillator `out` for current `index`.
- `osc_enabled`  in  1  oscillator `enabled` for current `index`.
- `index`  out  $clog2(N_WAVEGENS+1)  voice select to oscillator.
- `out`  out  OUT_WIDTH  signed mixed sample.
- `out_valid`  out  1  `out` holds an untaken sample.
- `out_ready`  in  1  consumer accepts `out` when high with `out_valid`.
- `active_voices`  out  $clog2(N_WAVEGENS+1)  count of `osc_enabled` in last delivered frame.
- `clip`  out  1  last delivered sample was saturated.
- `status`  out  2  sticky: bit0 start missed, bit1 output overrun.

## Operation

- FSM: IDLE → SWEEP → MUL → SAT → IDLE.
- IDLE: `index` = N_WAVEGENS (oscillator idle value). On `start`: acc ← 0, cnt ← 0, `index` ← 0, → SWEEP.
- SWEEP: each cycle acc ← acc + sign-extended `osc_out`, cnt ← cnt + `osc_enabled`, `index` ← `index`+1. When edge samples `index` = N_WAVEGENS−1: `index` ← N_WAVEGENS, → MUL.
- acc width WIDTH+FRAC+$clog2(N_WAVEGENS)+1, signed; never overflows.
- MUL: prod ← acc × {1'b0, `master_volume`} (signed), registered.
- SAT: s = prod >>> (8+FRAC) (arithmetic); clamp to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]; load `out`, `clip` (1 if clamped), `active_voices` ← cnt; `out_valid` ← 1; → IDLE.
- Handshake: sample transferred on edge where `out_valid` && `out_ready`; `out_valid` then clears unless SAT loads the same edge (then stays 1 with new data).
- Overrun: SAT while `out_valid` && !`out_ready` → overwrite `out`, keep `out_valid`=1, set `status[1]`.
- `start` outside IDLE is ignored and sets `status[0]`; frame in progress unaffected.
- `status` bits clear only on reset.
- `master_volume` sampled in MUL only.

## Timing

- Reset (async assert, any state): state IDLE, `index` = N_WAVEGENS, `out` = 0, `out_valid` = 0, `clip` = 0, `active_voices` = 0, `status` = 0, acc/cnt/prod = 0. Deassertion synchronous to `clk`; no output glitch beyond reset values.
- Let E0 be edge sampling `start` in IDLE. `index` = k during cycle after edge E(k), k = 0..N_WAVEGENS−1... i.e. `index` = 0 after E0, = k after Ek.
- Voice k's `osc_out` is accumulated at edge E(k+1); `index` = N_WAVEGENS after E(N_WAVEGENS).
- MUL edge E(N_WAVEGENS+1); SAT edge E(N_WAVEGENS+2); `out_valid` high after it. Latency `start`→`out_valid`: N_WAVEGENS+2 cycles.
- Minimum frame spacing: N_WAVEGENS+3 cycles; `start` at E(N_WAVEGENS+3) or later is accepted; earlier sets `status[0]`.
- `start` on same edge as reset deassert: ignored.

## Test plan

- Reset: hold `rstn`=0 mid-SWEEP → immediately `index`=4, `out_valid`=0, `status`=0 (N_WAVEGENS=4 for all tests).
- Basic sum: voices out 100,200,−50,0 (×2^FRAC), enabled 1,1,1,0, volume 128 → `out`=125, `active_voices`=3, `clip`=0, `out_valid` rises 6 cycles after `start`.
- Saturation: all voices 2^23−1 (×2^FRAC), volume 255, OUT_WIDTH=24 → `out`=8388607, `clip`=1; all −2^23 → `out`=−8388608, `clip`=1.
- Handshake/overrun: `out_ready`=0 across two frames → second sample replaces first, `out_valid` stays 1, `status[1]`=1; then `out_ready`=1 one cycle → `out_valid`=0.
- Early start: `start` 3 cycles after prior `start` → ignored, `status[0]`=1, in-flight frame result correct; `start` at 7 cycles → accepted.
- Index sweep check: monitor `index` sequence 4,0,1,2,3,4 per frame; never >4, never skipped.
